// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_READY,
    S_MOVE,
    S_SCAN,
    S_ERASE,
    S_WRITE,
    S_DRAW,
    S_DEAD
  } state_t;

  // Pixel origin of a cell; the caller truncates to its port width.
  function automatic logic [31:0] cell_to_px(input logic [31:0] cell_idx, input int unsigned cell_px);
    return cell_idx * cell_px;
  endfunction

  // Opposite heading: up<->down and left<->right differ only in bit 0.
  function automatic dir_t dir_reverse(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// Segment store: single-port synchronous RAM, read-before-write, one-cycle read latency.
module snake_seg_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Registered read of the old contents, then optional write to the same address.
  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: circular segment buffer, collision checks, growth and plot commands.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int CELL     = 4,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              step,
  input  logic [1:0]                        dir,
  input  logic [$clog2(GRID_W)-1:0]         food_x,
  input  logic [$clog2(GRID_H)-1:0]         food_y,
  output logic                              busy,
  output logic                              dead,
  output logic                              ate,
  output logic [$clog2(MAX_LEN+1)-1:0]      length,
  output logic [$clog2(GRID_W)-1:0]         head_x,
  output logic [$clog2(GRID_H)-1:0]         head_y,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic                              cmd_erase,
  output logic [$clog2(GRID_W*CELL)-1:0]    cmd_x,
  output logic [$clog2(GRID_H*CELL)-1:0]    cmd_y
);

  localparam int XW  = $clog2(GRID_W);
  localparam int YW  = $clog2(GRID_H);
  localparam int LW  = $clog2(MAX_LEN+1);
  localparam int PW  = $clog2(MAX_LEN);
  localparam int PXW = $clog2(GRID_W*CELL);
  localparam int PYW = $clog2(GRID_H*CELL);

  localparam logic [XW-1:0] CX    = XW'(GRID_W/2);
  localparam logic [YW-1:0] CY    = YW'(GRID_H/2);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W-1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H-1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] K_END = LW'(INIT_LEN);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_LEN-1)) ? '0 : p + PW'(1);
  endfunction

  state_t          state, state_d;
  dir_t            dir_q, eff_dir;
  logic [PW-1:0]   hd_ptr, tl_ptr, scan_ptr;
  logic [LW-1:0]   scan_left, k;
  logic            rd_vld_p1, er_ph;
  logic [XW-1:0]   nx, nxt_x;
  logic [YW-1:0]   ny, nxt_y, init_y;
  logic            grow, wall, eat_c, grow_c, hit, issue;
  logic            ram_we;
  logic [PW-1:0]   ram_addr;
  logic [XW+YW-1:0] ram_wdata, ram_rdata;

  snake_seg_ram #(.DEPTH(MAX_LEN), .W(XW+YW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign busy   = !(state == S_IDLE || state == S_READY || state == S_DEAD);
  assign issue  = !cmd_valid || cmd_ready;
  assign init_y = CY + YW'(k);
  assign hit    = rd_vld_p1 && (ram_rdata == {nx, ny});
  assign eat_c  = (nxt_x == food_x) && (nxt_y == food_y);
  assign grow_c = eat_c && (length < MAX_L);

  // Heading filter (reversal ignored) and next head cell with wrap/wall handling.
  always_comb begin
    eff_dir = dir_t'(dir);
    if (dir_t'(dir) == dir_reverse(dir_q)) eff_dir = dir_q;
    nxt_x = head_x;
    nxt_y = head_y;
    wall  = 1'b0;
    case (eff_dir)
      DIR_UP:    if (head_y == '0)    begin nxt_y = Y_MAX; wall = (WRAP == 0); end
                 else nxt_y = head_y - YW'(1);
      DIR_DOWN:  if (head_y == Y_MAX) begin nxt_y = '0;    wall = (WRAP == 0); end
                 else nxt_y = head_y + YW'(1);
      DIR_LEFT:  if (head_x == '0)    begin nxt_x = X_MAX; wall = (WRAP == 0); end
                 else nxt_x = head_x - XW'(1);
      DIR_RIGHT: if (head_x == X_MAX) begin nxt_x = '0;    wall = (WRAP == 0); end
                 else nxt_x = head_x + XW'(1);
      default: ;
    endcase
  end

  // Next-state and segment RAM port control.
  always_comb begin
    state_d   = state;
    ram_we    = 1'b0;
    ram_addr  = scan_ptr;
    ram_wdata = {nx, ny};
    case (state)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT: begin
        if (issue && k != K_END) begin
          ram_we    = 1'b1;
          ram_addr  = PW'(INIT_LEN-1) - k[PW-1:0];
          ram_wdata = {CX, init_y};
        end
        if (issue && k == K_END) state_d = S_READY;
      end
      S_READY: begin
        if (start)     state_d = S_INIT;
        else if (step) state_d = S_MOVE;
      end
      S_MOVE:  state_d = wall ? S_DEAD : S_SCAN;
      S_SCAN: begin
        if (hit) state_d = S_DEAD;
        else if (scan_left == '0 && !rd_vld_p1) state_d = grow ? S_WRITE : S_ERASE;
      end
      S_ERASE: begin
        ram_addr = tl_ptr;
        if (er_ph && cmd_valid && cmd_ready) state_d = S_WRITE;
      end
      S_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = ptr_inc(hd_ptr);
        state_d  = S_DRAW;
      end
      S_DRAW:  if (cmd_ready) state_d = S_READY;
      S_DEAD:  if (start) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Move candidate captured once per step; no reset needed on these datapath registers.
  always_ff @(posedge clk) begin
    if (state == S_MOVE) begin
      nx   <= nxt_x;
      ny   <= nxt_y;
      grow <= grow_c;
    end
  end

  // Control registers, pointers, status outputs and the plot command slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_erase <= 1'b0;
      cmd_x     <= '0;
      cmd_y     <= '0;
      dead      <= 1'b0;
      ate       <= 1'b0;
      length    <= '0;
      head_x    <= '0;
      head_y    <= '0;
      hd_ptr    <= '0;
      tl_ptr    <= '0;
      dir_q     <= DIR_UP;
      k         <= '0;
      scan_ptr  <= '0;
      scan_left <= '0;
      rd_vld_p1 <= 1'b0;
      er_ph     <= 1'b0;
    end else begin
      ate <= 1'b0;
      case (state)
        S_IDLE, S_READY, S_DEAD: begin
          if (start) begin
            k      <= '0;
            dead   <= 1'b0;
            dir_q  <= DIR_UP;
            hd_ptr <= PW'(INIT_LEN-1);
            tl_ptr <= '0;
            head_x <= CX;
            head_y <= CY;
          end
        end
        S_INIT: begin
          if (issue) begin
            if (k != K_END) begin
              cmd_valid <= 1'b1;
              cmd_erase <= 1'b0;
              cmd_x     <= PXW'(cell_to_px(32'(CX), CELL));
              cmd_y     <= PYW'(cell_to_px(32'(init_y), CELL));
              k         <= k + LW'(1);
            end else begin
              cmd_valid <= 1'b0;
              length    <= K_END;
            end
          end
        end
        S_MOVE: begin
          dir_q <= eff_dir;
          if (wall) begin
            dead <= 1'b1;
          end else begin
            ate       <= eat_c;
            rd_vld_p1 <= 1'b0;
            er_ph     <= 1'b0;
            if (grow_c) begin
              scan_ptr  <= tl_ptr;
              scan_left <= length;
            end else begin
              scan_ptr  <= ptr_inc(tl_ptr);
              scan_left <= length - LW'(1);
            end
          end
        end
        S_SCAN: begin
          rd_vld_p1 <= (scan_left != '0);
          if (scan_left != '0) begin
            scan_ptr  <= ptr_inc(scan_ptr);
            scan_left <= scan_left - LW'(1);
          end
          if (hit) dead <= 1'b1;
        end
        S_ERASE: begin
          if (!er_ph) begin
            er_ph <= 1'b1;
          end else if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_erase <= 1'b1;
            cmd_x     <= PXW'(cell_to_px(32'(ram_rdata[XW+YW-1:YW]), CELL));
            cmd_y     <= PYW'(cell_to_px(32'(ram_rdata[YW-1:0]), CELL));
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            tl_ptr    <= ptr_inc(tl_ptr);
          end
        end
        S_WRITE: begin
          hd_ptr    <= ptr_inc(hd_ptr);
          head_x    <= nx;
          head_y    <= ny;
          if (grow) length <= length + LW'(1);
          cmd_valid <= 1'b1;
          cmd_erase <= 1'b0;
          cmd_x     <= PXW'(cell_to_px(32'(nx), CELL));
          cmd_y     <= PYW'(cell_to_px(32'(ny), CELL));
        end
        S_DRAW: if (cmd_ready) cmd_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine with a queue-based snake model and a command scoreboard.
module tb_snake_body_engine;

  localparam int GW = 40, GH = 30, CELL = 4, MAXL = 64, IL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, step = 1'b0, cmd_ready = 1'b1;
  logic [1:0] dir = 2'b00;
  logic [5:0] food_x = '0;
  logic [4:0] food_y = '0;
  logic       busy, dead, ate, cmd_valid, cmd_erase;
  logic [6:0] length;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;

  logic       start_nw = 1'b0, step_nw = 1'b0, ready_nw = 1'b1;
  logic [1:0] dir_nw = 2'b00;
  logic       busy_nw, dead_nw, ate_nw, valid_nw, erase_nw;
  logic [6:0] length_nw;
  logic [5:0] head_x_nw;
  logic [4:0] head_y_nw;
  logic [7:0] cmd_x_nw;
  logic [6:0] cmd_y_nw;

  snake_body_engine #(.GRID_W(GW), .GRID_H(GH), .CELL(CELL), .MAX_LEN(MAXL), .INIT_LEN(IL), .WRAP(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir),
    .food_x(food_x), .food_y(food_y), .busy(busy), .dead(dead), .ate(ate),
    .length(length), .head_x(head_x), .head_y(head_y),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_erase(cmd_erase),
    .cmd_x(cmd_x), .cmd_y(cmd_y)
  );

  snake_body_engine #(.GRID_W(GW), .GRID_H(GH), .CELL(CELL), .MAX_LEN(MAXL), .INIT_LEN(IL), .WRAP(0)) u_dut_nw (
    .clk(clk), .rst(rst), .start(start_nw), .step(step_nw), .dir(dir_nw),
    .food_x(food_x), .food_y(food_y), .busy(busy_nw), .dead(dead_nw), .ate(ate_nw),
    .length(length_nw), .head_x(head_x_nw), .head_y(head_y_nw),
    .cmd_valid(valid_nw), .cmd_ready(ready_nw), .cmd_erase(erase_nw),
    .cmd_x(cmd_x_nw), .cmd_y(cmd_y_nw)
  );

  typedef struct { int x; int y; } cell_t;
  typedef struct { int erase; int x; int y; } cmd_t;

  cell_t body[$];
  cmd_t  exp_q[$];
  int    mdir;
  bit    mdead;
  int    n_cmp = 0, n_bad = 0;
  int    ate_cnt = 0;
  int    last_px = -1, last_py = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: fresh snake, head in the middle, body trailing downward.
  task automatic model_start();
    body.delete();
    for (int i = 0; i < IL; i++) begin
      body.push_back('{GW/2, GH/2 + i});
      exp_q.push_back('{0, (GW/2)*CELL, (GH/2 + i)*CELL});
    end
    mdir  = 0;
    mdead = 1'b0;
  endtask

  // Model: one step of the game rules on the queue.
  task automatic model_step(input int d, input int fx, input int fy, output bit eat);
    int  eff, nx, ny, lim;
    bit  grow, hit;
    eff = d;
    if ((d == 0 && mdir == 1) || (d == 1 && mdir == 0) ||
        (d == 2 && mdir == 3) || (d == 3 && mdir == 2)) eff = mdir;
    mdir = eff;
    nx = body[0].x;
    ny = body[0].y;
    case (eff)
      0: ny = (ny + GH - 1) % GH;
      1: ny = (ny + 1) % GH;
      2: nx = (nx + GW - 1) % GW;
      default: nx = (nx + 1) % GW;
    endcase
    eat  = (nx == fx) && (ny == fy);
    grow = eat && (body.size() < MAXL);
    lim  = grow ? body.size() : body.size() - 1;
    hit  = 1'b0;
    for (int i = 0; i < lim; i++)
      if (body[i].x == nx && body[i].y == ny) hit = 1'b1;
    if (hit) begin
      mdead = 1'b1;
    end else begin
      if (!grow) begin
        exp_q.push_back('{1, body[body.size()-1].x*CELL, body[body.size()-1].y*CELL});
        void'(body.pop_back());
      end
      exp_q.push_back('{0, nx*CELL, ny*CELL});
      body.push_front('{nx, ny});
    end
  endtask

  // Scoreboard: every transfer must match the next expected command; stalled commands must hold.
  bit         hold_prev = 1'b0;
  logic [7:0] sv_x;
  logic [6:0] sv_y;
  logic       sv_e;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", int'(cmd_valid), 1);
        chk("stall_x", int'(cmd_x), int'(sv_x));
        chk("stall_y", int'(cmd_y), int'(sv_y));
        chk("stall_erase", int'(cmd_erase), int'(sv_e));
      end
      hold_prev = cmd_valid && !cmd_ready;
      sv_x = cmd_x; sv_y = cmd_y; sv_e = cmd_erase;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 1, 0);
        end else begin
          cmd_t c;
          c = exp_q.pop_front();
          chk("cmd_erase", int'(cmd_erase), c.erase);
          chk("cmd_x", int'(cmd_x), c.x);
          chk("cmd_y", int'(cmd_y), c.y);
        end
        last_px = int'(cmd_x);
        last_py = int'(cmd_y);
      end
      if (ate) ate_cnt++;
    end
  end

  task automatic wait_idle(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 1000) begin tick(); cnt++; end
    if (cnt >= 1000) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic check_model(input string tag, input int ate_exp, input int a0);
    chk({tag, "_head_x"}, int'(head_x), body[0].x);
    chk({tag, "_head_y"}, int'(head_y), body[0].y);
    chk({tag, "_length"}, int'(length), body.size());
    chk({tag, "_dead"}, int'(dead), int'(mdead));
    chk({tag, "_ate_pulses"}, ate_cnt - a0, ate_exp);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_start(input string tag);
    int a0;
    model_start();
    a0 = ate_cnt;
    tick(); start = 1'b1; tick(); start = 1'b0;
    wait_idle(tag);
    check_model(tag, 0, a0);
  endtask

  task automatic do_step(input string tag, input int d);
    bit eat;
    int a0;
    model_step(d, int'(food_x), int'(food_y), eat);
    a0 = ate_cnt;
    tick(); dir = 2'(d); step = 1'b1; tick(); step = 1'b0;
    wait_idle(tag);
    check_model(tag, int'(eat), a0);
  endtask

  task automatic step_nw_run(input int d, output int ncmd);
    int cnt;
    ncmd = 0;
    tick(); dir_nw = 2'(d); step_nw = 1'b1; tick(); step_nw = 1'b0;
    cnt = 0;
    while (busy_nw && cnt < 1000) begin
      if (valid_nw) ncmd++;
      tick(); cnt++;
    end
    if (cnt >= 1000) chk("nw_step_timeout", 1, 0);
  endtask

  task automatic start_nw_run();
    int cnt;
    tick(); start_nw = 1'b1; tick(); start_nw = 1'b0;
    cnt = 0;
    while (busy_nw && cnt < 1000) begin tick(); cnt++; end
    if (cnt >= 1000) chk("nw_start_timeout", 1, 0);
  endtask

  initial begin
    int   ncmd, a0;
    bit   eat;
    logic [7:0] hx;
    logic [6:0] hy;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_dead", int'(dead), 0);
    chk("rst_ate", int'(ate), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_length", int'(length), 0);
    chk("rst_head_x", int'(head_x), 0);
    chk("rst_head_y", int'(head_y), 0);
    chk("rst_cmd_x", int'(cmd_x), 0);
    chk("rst_cmd_y", int'(cmd_y), 0);
    rst = 1'b0;
    tick();

    // Start: three draws at (80,60),(80,64),(80,68).
    do_start("start");
    chk("lit_start_head_x", int'(head_x), 20);
    chk("lit_start_head_y", int'(head_y), 15);
    chk("lit_start_len", int'(length), 3);
    chk("lit_start_last_py", last_py, 68);

    // Plain step up.
    do_step("up1", 0);
    chk("lit_up1_head_y", int'(head_y), 14);
    chk("lit_up1_draw_py", last_py, 56);

    // Eat food directly ahead: grow, no erase.
    food_x = 6'd20; food_y = 5'd13;
    do_step("eat", 0);
    chk("lit_eat_len", int'(length), 4);
    chk("lit_eat_draw_py", last_py, 52);
    food_x = '0; food_y = '0;

    // Reversal request is ignored.
    do_step("rev", 1);
    chk("lit_rev_head_y", int'(head_y), 12);

    // Walk left to x=0, then wrap to x=39.
    for (int i = 0; i < 20; i++) do_step("left", 2);
    chk("lit_left_head_x", int'(head_x), 0);
    do_step("wrap", 2);
    chk("lit_wrap_head_x", int'(head_x), 39);
    chk("lit_wrap_draw_px", last_px, 156);

    // Restart, grow to 5, then curl back into the body.
    do_start("restart1");
    food_x = 6'd20; food_y = 5'd14; do_step("grow4", 0);
    food_x = 6'd20; food_y = 5'd13; do_step("grow5", 0);
    food_x = '0; food_y = '0;
    do_step("loop_up", 0);
    do_step("loop_left", 2);
    do_step("loop_down", 1);
    do_step("loop_right", 3);
    chk("lit_selfhit_dead", int'(dead), 1);
    chk("lit_selfhit_len", int'(length), 5);
    chk("lit_selfhit_head_x", int'(head_x), 19);

    // Restart out of DEAD, then a length-4 loop re-entering the vacating tail.
    do_start("restart2");
    chk("lit_restart_dead", int'(dead), 0);
    food_x = 6'd20; food_y = 5'd14; do_step("tgrow", 0);
    food_x = '0; food_y = '0;
    do_step("tail_left", 2);
    do_step("tail_down", 1);
    do_step("tail_right", 3);
    chk("lit_tail_alive", int'(dead), 0);
    chk("lit_tail_head_x", int'(head_x), 20);
    chk("lit_tail_head_y", int'(head_y), 15);
    chk("lit_tail_draw_px", last_px, 80);
    chk("lit_tail_draw_py", last_py, 60);

    // Backpressure during the erase; step pulses in the meantime are ignored.
    model_step(0, int'(food_x), int'(food_y), eat);
    a0 = ate_cnt;
    cmd_ready = 1'b0;
    tick(); dir = 2'b00; step = 1'b1; tick(); step = 1'b0;
    ncmd = 0;
    while (!cmd_valid && ncmd < 100) begin tick(); ncmd++; end
    chk("bp_valid_rise", int'(cmd_valid), 1);
    chk("bp_erase", int'(cmd_erase), 1);
    hx = cmd_x; hy = cmd_y;
    for (int i = 0; i < 10; i++) begin
      tick();
      step = (i % 2 == 1);
    end
    step = 1'b0;
    tick();
    chk("bp_valid_held", int'(cmd_valid), 1);
    chk("bp_x_held", int'(cmd_x), int'(hx));
    chk("bp_y_held", int'(cmd_y), int'(hy));
    chk("lit_bp_x", int'(hx), 80);
    chk("lit_bp_y", int'(hy), 56);
    cmd_ready = 1'b1;
    wait_idle("bp");
    check_model("bp", int'(eat), a0);

    // Non-wrapping build: walking off the left edge kills without commands.
    start_nw_run();
    chk("nw_start_len", int'(length_nw), 3);
    chk("nw_start_head_x", int'(head_x_nw), 20);
    for (int i = 0; i < 20; i++) step_nw_run(2, ncmd);
    chk("nw_edge_head_x", int'(head_x_nw), 0);
    chk("nw_edge_alive", int'(dead_nw), 0);
    step_nw_run(2, ncmd);
    chk("nw_wall_dead", int'(dead_nw), 1);
    chk("nw_wall_cmds", ncmd, 0);
    chk("nw_wall_head_x", int'(head_x_nw), 0);
    start_nw_run();
    chk("nw_restart_dead", int'(dead_nw), 0);
    chk("nw_restart_head_x", int'(head_x_nw), 20);
    chk("nw_restart_head_y", int'(head_y_nw), 15);
    chk("nw_restart_len", int'(length_nw), 3);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Parametrised snake body engine: keeps the snake as a circular buffer of grid cells and advances it one cell per `step` pulse.
- Detects wall and self collisions, handles food and growth up to MAX_LEN, and emits erase/draw plot commands in pixel coordinates through a valid/ready interface.
- Sits between the game-control FSM (start/step/dir, food position) and the pixel plotter/VGA adapter.

Parameters:
- GRID_W, 40, playfield width in cells
- GRID_H, 30, playfield height in cells
- CELL, 4, cell edge in pixels; cmd_x = cx*CELL, cmd_y = cy*CELL
- MAX_LEN, 64, maximum segments; buffer depth
- INIT_LEN, 3, segments after start (2..MAX_LEN)
- WRAP, 1, 1 = edges wrap around, 0 = edges kill

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; (re)initialise snake
- step  in  1  pulse; advance one cell
- dir  in  2  00 up, 01 down, 10 left, 11 right
- food_x  in  clog2(GRID_W)  food cell x
- food_y  in  clog2(GRID_H)  food cell y
- busy  out  1  high whenever FSM not in IDLE/READY/DEAD
- dead  out  1  sticky collision flag
- ate  out  1  one-cycle pulse when head lands on food
- length  out  clog2(MAX_LEN+1)  current segment count
- head_x, head_y  out  cell widths  current head cell
- cmd_valid  out  1  plot command valid
- cmd_ready  in  1  plotter accepts
- cmd_erase  out  1  1 = erase cell, 0 = draw cell
- cmd_x  out  clog2(GRID_W*CELL)  pixel x of cell origin
- cmd_y  out  clog2(GRID_H*CELL)  pixel y of cell origin

Behaviour:
- Reset: FSM=IDLE.
  - All outputs 0: cmd_valid, dead, ate, busy, length, head_x/y, cmd_*.
  - Buffer pointers 0, stored direction = up.
  - rst mid-operation aborts everything, including any pending command.
- Buffer: MAX_LEN entries {x,y}; hd_ptr, tl_ptr, both mod MAX_LEN. Read is one cycle from address to data.
- Command handshake:
  - A transfer occurs on a cycle with cmd_valid & cmd_ready.
  - While cmd_valid is high, cmd_x/cmd_y/cmd_erase stay stable until that transfer.
  - cmd_valid never drops without a transfer, except on rst.
- IDLE: waits for start.
- INIT (start accepted in IDLE, READY or DEAD):
  - Clears dead. Head = (GRID_W/2, GRID_H/2).
  - Segment k = (GRID_W/2, GRID_H/2+k) for k = 0..INIT_LEN-1, written one per cycle.
  - Emits INIT_LEN draw commands, head first. Stored direction = up.
  - Then length = INIT_LEN, FSM → READY.
- READY: waits for step.
  - step in any other state is ignored.
  - start is honoured only in IDLE/READY/DEAD.
- MOVE (1 cycle):
  - dir equal to the reverse of the stored direction is ignored (old direction kept); otherwise dir is latched.
  - Compute the next head.
  - Leaving the grid: WRAP=1 → wrap to opposite edge (x=0 left → GRID_W-1, x=GRID_W-1 right → 0, same for y). WRAP=0 → dead=1, FSM → DEAD, no commands.
  - grow = (next == food) && length < MAX_LEN.
  - eat = (next == food); ate pulses for exactly one cycle here even when at MAX_LEN.
- SCAN:
  - Compare next head against the occupied segments, one per cycle, tail to head.
  - When !grow the tail entry is skipped, because it vacates.
  - Any match → dead=1, FSM → DEAD.
- ERASE (!grow only): emit erase of the tail cell, then tl_ptr++.
- WRITE: hd_ptr++, store next head, update head_x/y.
  - If grow: length++.
  - Otherwise length is unchanged.
- DRAW: emit draw of the new head. Erase always precedes draw, so a head moving into the just-vacated tail cell remains drawn. FSM → READY.
- DEAD: all state frozen, outputs held, dead=1; only start or rst leaves.
- Arithmetic: cell coordinates are unsigned; pixel coordinate = cell*CELL, computed at full command-port width.

Decomposition:
- Shared package snake_pkg:
  - direction encodings (DIR_UP/DOWN/LEFT/RIGHT)
  - FSM state enum (IDLE, INIT, READY, MOVE, SCAN, ERASE, WRITE, DRAW, DEAD)
  - cell-to-pixel helper function
- One natural sub-module, snake_seg_ram: MAX_LEN×(cell-x+cell-y) single-port synchronous RAM, read-before-write, one-cycle read latency.

Test Plan (defaults, cmd_ready=1 unless stated):
- rst then start → draws at pixels (80,60), (80,64), (80,68); length=3, busy falls, dead=0.
- step dir=up, food elsewhere → erase (80,68) then draw (80,56); head=(20,14), length=3, ate=0.
- food=(20,13), step up → ate pulses 1 cycle, no erase, draw (80,52), length=4. Step dir=down (reversal) → ignored, head moves to (20,12).
- Steer the snake to x=0, step left. WRAP=1 → head x=39, draw at pixel x=156. WRAP=0 build → dead=1, no commands. Then start → snake re-initialised, dead=0.
- Grow to length 5, then up, left, down, right → dead=1 on the head/body hit. Separately, a length-4 loop re-entering the vacating tail cell → stays alive, erase before draw at the same pixel.
- cmd_ready held low 10 cycles during the erase → cmd_valid stays 1, cmd_x/cmd_y stable; step pulses meanwhile are ignored; after release the erase then the draw complete in order.
